// File: rtl/mips_muldiv_unit_if.sv
// Request/result bundle between the core's execute stage and the HI/LO multiply/divide unit.
interface mips_muldiv_unit_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  start;
  logic [2:0]            op;
  logic [DATA_WIDTH-1:0] src_a;
  logic [DATA_WIDTH-1:0] src_b;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] hi;
  logic [DATA_WIDTH-1:0] lo;

  // Core side: issues requests, watches busy/done, reads HI/LO.
  modport master (
    output start, op, src_a, src_b,
    input  busy, done, hi, lo
  );

  // Unit side.
  modport slave (
    input  start, op, src_a, src_b,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mips_muldiv_unit.sv
// Iterative MIPS multiply/divide unit owning HI/LO.
// One bit per cycle for MULT/MULTU/DIV/DIVU on magnitudes, sign fix-up in FIX;
// MTHI/MTLO write in a single cycle. DATA_WIDTH must be at least 2.
module mips_muldiv_unit #(
  parameter int DATA_WIDTH = 32,
  parameter bit EARLY_DIV0 = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  mips_muldiv_unit_if.slave  bus
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   count_reg;
  logic [2*W-1:0]  acc_reg;      // mul: {partial, multiplier}; div: {remainder, dividend/quotient}
  logic [W-1:0]    mag_reg;      // |multiplicand| or |divisor|
  logic [W-1:0]    a_raw_reg;    // raw rs value, returned in HI on divide by zero
  logic [W-1:0]    hi_reg, lo_reg;
  logic            neg_q_reg;    // negate product / quotient
  logic            neg_r_reg;    // negate remainder
  logic            is_div_reg;
  logic            div0_reg;
  logic            done_reg;

  // Request decode
  logic          accept, op_mul, op_div, op_mthi, op_mtlo, div_zero;
  logic          sign_a, sign_b;
  logic [W-1:0]  abs_a, abs_b;

  // Datapath step/fix-up values
  logic [W:0]     mul_sum;
  logic [2*W-1:0] mul_next;
  logic [W:0]     div_shift;
  logic [W:0]     div_diff;
  logic           div_fits;
  logic [2*W-1:0] div_next;
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   quo_fix, rem_fix;

  // Decode the incoming request and form operand magnitudes
  always_comb begin
    accept   = bus.start && (state_reg == IDLE);
    op_mul   = (bus.op == 3'b000) || (bus.op == 3'b001);
    op_div   = (bus.op == 3'b010) || (bus.op == 3'b011);
    op_mthi  = (bus.op == 3'b100);
    op_mtlo  = (bus.op == 3'b101);
    div_zero = (bus.src_b == '0);
    // op[0]=0 selects the signed variant of both MULT and DIV
    sign_a   = ~bus.op[0] && bus.src_a[W-1];
    sign_b   = ~bus.op[0] && bus.src_b[W-1];
    abs_a    = sign_a ? -bus.src_a : bus.src_a;
    abs_b    = sign_b ? -bus.src_b : bus.src_b;
  end

  // One shift-add / restoring-subtract step, plus the final sign correction
  always_comb begin
    mul_sum   = {1'b0, acc_reg[2*W-1:W]} + (acc_reg[0] ? {1'b0, mag_reg} : '0);
    mul_next  = {mul_sum, acc_reg[W-1:1]};
    div_shift = acc_reg[2*W-1:W-1];
    div_fits  = (div_shift >= {1'b0, mag_reg});
    div_diff  = div_shift - {1'b0, mag_reg};
    div_next  = div_fits ? {div_diff[W-1:0], acc_reg[W-2:0], 1'b1}
                         : {div_shift[W-1:0], acc_reg[W-2:0], 1'b0};
    prod_fix  = neg_q_reg ? -acc_reg : acc_reg;
    quo_fix   = neg_q_reg ? -acc_reg[W-1:0] : acc_reg[W-1:0];
    rem_fix   = neg_r_reg ? -acc_reg[2*W-1:W] : acc_reg[2*W-1:W];
  end

  // Sequencer next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept && op_mul) begin
          state_next = MUL;
        end else if (accept && op_div) begin
          state_next = (EARLY_DIV0 && div_zero) ? FIX : DIV;
        end
      end
      MUL, DIV: begin
        if (count_reg == '0) begin
          state_next = FIX;
        end
      end
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Sequencer state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Operand capture, iteration, HI/LO writes and the done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg  <= '0;
      acc_reg    <= '0;
      mag_reg    <= '0;
      a_raw_reg  <= '0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      is_div_reg <= 1'b0;
      div0_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            count_reg  <= CW'(W - 1);
            a_raw_reg  <= bus.src_a;
            neg_q_reg  <= sign_a ^ sign_b;
            neg_r_reg  <= sign_a;
            is_div_reg <= op_div;
            div0_reg   <= div_zero;
            if (op_mul) begin
              acc_reg <= {{W{1'b0}}, abs_b};
              mag_reg <= abs_a;
            end else if (op_div) begin
              acc_reg <= {{W{1'b0}}, abs_a};
              mag_reg <= abs_b;
            end
            if (op_mthi) hi_reg <= bus.src_a;
            if (op_mtlo) lo_reg <= bus.src_a;
          end
        end
        MUL: begin
          acc_reg   <= mul_next;
          count_reg <= count_reg - CW'(1);
        end
        DIV: begin
          acc_reg   <= div_next;
          count_reg <= count_reg - CW'(1);
        end
        FIX: begin
          done_reg <= 1'b1;
          if (is_div_reg && div0_reg) begin
            hi_reg <= a_raw_reg;
            lo_reg <= '1;
          end else if (is_div_reg) begin
            hi_reg <= rem_fix;
            lo_reg <= quo_fix;
          end else begin
            {hi_reg, lo_reg} <= prod_fix;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state_reg != IDLE);
  assign bus.done = done_reg;
  assign bus.hi   = hi_reg;
  assign bus.lo   = lo_reg;
endmodule

// File: doc/mips_muldiv_unit.md
Name: mips_muldiv_unit

Overview:
- Parametrised multiply/divide unit that owns the HI/LO register pair for the MIPS core.
- Executes MULT, MULTU, DIV and DIVU iteratively at one bit per cycle. Executes MTHI and MTLO in a single cycle.
- Exposes HI and LO continuously so the core can serve MFHI/MFLO.
- Sits beside the ALU in the execute stage. The core stalls on busy before issuing MFHI, MFLO or another muldiv op.

Parameters:
- DATA_WIDTH, 32: operand width; HI and LO are each DATA_WIDTH bits.
- EARLY_DIV0, 1: 1 = divide-by-zero completes in 1 cycle; 0 = runs the full iteration count.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  op request; sampled only when busy=0.
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others = no-op.
- src_a  in  DATA_WIDTH  rs value: multiplicand, dividend, or move source.
- src_b  in  DATA_WIDTH  rt value: multiplier or divisor.
- busy  out  1  high while an iterative op is in flight.
- done  out  1  one-cycle pulse when HI/LO are updated by mul/div.
- hi  out  DATA_WIDTH  HI register.
- lo  out  DATA_WIDTH  LO register.

Behaviour:
- Reset (rst=1 at a rising edge): hi=0, lo=0, busy=0, done=0, FSM=IDLE. Reset overrides everything, including mid-operation; an aborted op produces no done pulse and no HI/LO write.
- FSM states: IDLE, MUL, DIV, FIX.
  - IDLE: start with op=MULT/MULTU -> MUL; start with op=DIV/DIVU -> DIV.
  - MUL or DIV: counter runs DATA_WIDTH-1 down to 0; at 0 -> FIX.
  - FIX: -> IDLE.
- Timing (edge E0 samples start):
  - busy=1 from E0 until E(W+1), where W=DATA_WIDTH.
  - Iterations occur at E1..EW.
  - FIX at E(W+1) applies sign correction, writes hi/lo, and drives done=1 for exactly the following cycle.
  - Latency from start to result is W+1 cycles.
- Operand capture: operands are captured at E0. src_a and src_b may change afterwards without effect.
- Signed ops (MULT, DIV):
  - Magnitudes are computed with |x| as a W-bit unsigned value, so |MIN| = 2^(W-1).
  - Product is negated when sign_a^sign_b.
  - Quotient is negated when sign_a^sign_b; remainder takes the sign of the dividend.
- Multiply: shift-add on a 2W-bit accumulator; {hi,lo} = the full 2W-bit product.
- Divide: restoring divider; lo = quotient, hi = remainder.
- Divide by zero (src_b=0, DIV or DIVU): lo = all ones, hi = src_a unchanged.
  - With EARLY_DIV0=1: goes IDLE -> FIX directly. busy is high for 1 cycle; done occurs after E1.
  - With EARLY_DIV0=0: takes the normal W+1 cycles and gives the same result.
- Signed overflow: DIV of MIN by -1 gives lo=MIN, hi=0. No trap is raised.
- MTHI/MTLO: with start=1 and busy=0, hi (or lo) = src_a at E0. No busy, no done.
- Undefined ops: op 110 or 111 with start is ignored and the FSM stays IDLE.
- start while busy=1 is ignored completely; this includes MTHI/MTLO. The core is responsible for stalling.
- Result timing: done and the new hi/lo values become visible in the same cycle. A start in the cycle where done=1 is accepted, since busy=0 then.

Test Plan:
- Reset then idle: rst=1 for one edge -> hi=0, lo=0, busy=0, done=0. Start with op=110 -> no state change.
- MULT signed:
  - src_a=FFFFFFFD (-3), src_b=00000005 -> busy for 33 cycles, then one done pulse.
  - Result hi=FFFFFFFF, lo=FFFFFFF1.
- MULTU: src_a=src_b=FFFFFFFF -> hi=FFFFFFFE, lo=00000001 after 33 cycles.
- DIV signed:
  - src_a=FFFFFFF9 (-7), src_b=2 -> lo=FFFFFFFD, hi=FFFFFFFF.
  - src_a=80000000, src_b=FFFFFFFF -> lo=80000000, hi=00000000.
- DIVU by zero: src_a=00000064, src_b=0.
  - EARLY_DIV0=1 -> done one cycle after start; lo=FFFFFFFF, hi=00000064.
  - EARLY_DIV0=0 -> same result after 33 cycles.
- Moves and interference:
  - MTHI 12345678 then MTLO 9ABCDEF0 -> hi/lo updated next edge, no done.
  - MULTU 2×3, with MTHI AAAAAAAA issued while busy -> ignored; final hi=0, lo=6.
  - A second MULTU during busy is also ignored.
  - rst asserted at cycle 10 of a DIVU -> hi=lo=0, busy=0, no done.
